// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline register, RUN/HALT fetch FSM and saturating fetch counter
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);
   typedef enum logic {RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d, fetch_count_q, fetch_count_d;
   logic        if_valid_q, if_valid_d;
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_pc_d       = if_pc_q;
      if_instr_d    = if_instr_q;
      if_valid_d    = if_valid_q;
      fetch_count_d = fetch_count_q;
      if (branch_taken) begin
         state_d    = RUN;
         pc_d       = branch_target;
         if_pc_d    = pc_q;
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end else if (state_q == RUN && !stall) begin
         if_pc_d = pc_q;
         if (instr_in == 32'h0) begin
            state_d    = HALT;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
         end else begin
            pc_d          = pc_q + 32'd4;
            if_instr_d    = instr_in;
            if_valid_d    = 1'b1;
            fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q : fetch_count_q + 32'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         if_pc_q       <= RESET_PC;
         if_instr_q    <= NOP_INSTR;
         if_valid_q    <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_pc_q       <= if_pc_d;
         if_instr_q    <= if_instr_d;
         if_valid_q    <= if_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end
   assign pc_out      = pc_q;
   assign if_id_pc    = if_pc_q;
   assign if_id_instr = if_instr_q;
   assign if_id_valid = if_valid_q;
   assign halted      = (state_q == HALT);
   assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetch scenarios checked against a rule-level reference model
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   logic        clk = 1'b0;
   logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] instr_in, pc_out, if_id_pc, if_id_instr, fetch_count;
   logic        if_id_valid, halted;
   logic [31:0] mem [0:63];
   logic [31:0] m_pc, m_if_pc, m_if_instr, m_cnt;
   logic        m_valid, m_halted;
   int          checks = 0, failures = 0;
   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr_in(instr_in), .pc_out(pc_out),
      .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .halted(halted), .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   assign instr_in = mem[pc_out[7:2]];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
      logic [31:0] ins;
      rst = r; stall = s; branch_taken = b; branch_target = t;
      ins = mem[m_pc[7:2]];
      if (r) begin
         m_pc = RESET_PC; m_if_pc = RESET_PC; m_if_instr = NOP; m_valid = 0; m_halted = 0; m_cnt = 0;
      end else if (b) begin
         m_if_pc = m_pc; m_if_instr = NOP; m_valid = 0; m_halted = 0; m_pc = t;
      end else if (!m_halted && !s) begin
         m_if_pc = m_pc;
         if (ins == 0) begin
            m_halted = 1; m_if_instr = NOP; m_valid = 0;
         end else begin
            m_if_instr = ins; m_valid = 1; m_pc = m_pc + 4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         end
      end
      @(posedge clk);
      #1;
      chk("pc_out", pc_out, m_pc);
      chk("if_id_pc", if_id_pc, m_if_pc);
      chk("if_id_instr", if_id_instr, m_if_instr);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("fetch_count", fetch_count, m_cnt);
   endtask
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
      step(1, 0, 0, 0);
      chk("reset_pc", pc_out, 32'h0);
      chk("reset_instr", if_id_instr, 32'h13);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("seq_pc8", pc_out, 32'h8);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_ifid", if_id_instr, 32'h1000_0001);
      step(0, 1, 1, 32'h20);
      chk("br_stall_pc", pc_out, 32'h20);
      chk("br_stall_cnt", fetch_count, 32'd2);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("seq_cnt3", fetch_count, 32'd3);
      chk("seq_pc12", pc_out, 32'hC);
      mem[3] = 32'h0;
      step(0, 0, 0, 0);
      chk("halt_flag", {31'b0, halted}, 32'h1);
      for (int i = 0; i < 6; i++) step(0, i[0], 0, 0);
      chk("halt_pc_hold", pc_out, 32'hC);
      step(0, 0, 1, 32'h0);
      chk("halt_exit_pc", pc_out, 32'h0);
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_pc", pc_out, 32'h0);
      dut.fetch_count_q = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("sat_cnt", fetch_count, 32'hFFFF_FFFF);
      step(0, 1, 1, 32'h40);
      step(1, 1, 1, 32'h80);
      chk("mid_rst_cnt", fetch_count, 32'h0);
      step(0, 0, 1, 32'h7);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0)
            mem[$urandom_range(0, 63)] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
              $urandom_range(0, 19) < 3, $urandom_range(0, 255));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
